// File: rtl/load_store_unit.sv
// pd3 MIPS memory stage: LW/SW/LB/LBU/SB over a req/ack data-memory port with big-endian lanes.
// Defining LSU_MISALIGN_TRAP_EN makes misaligned LW/SW complete with a w_misalign_1 pulse instead of issuing.
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       w_op_code_6,
    input  logic             w_valid_1,
    output logic             w_ready_1,
    input  logic [WIDTH-1:0] w_alu_result_x,
    input  logic [WIDTH-1:0] w_store_data_x,
    input  logic [4:0]       w_dest_reg_5,
    output logic             w_mem_req_1,
    output logic             w_mem_we_1,
    output logic [WIDTH-1:0] w_mem_addr_x,
    output logic [WIDTH-1:0] w_mem_wdata_x,
    output logic [3:0]       w_mem_be_4,
    input  logic             w_mem_ack_1,
    input  logic [WIDTH-1:0] w_mem_rdata_x,
    output logic             w_wb_valid_1,
    output logic [WIDTH-1:0] w_wb_data_x,
    output logic [4:0]       w_wb_reg_5,
    output logic             w_misalign_1
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB, S_TRAP} state_t;

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [1:0]       lane_q, lane_d;
    logic [4:0]       dest_q, dest_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             wb_valid_q, wb_valid_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic [4:0]       wb_reg_q, wb_reg_d;
    logic             misalign_q, misalign_d;

    logic             in_is_word, in_is_store, in_is_mem, trap_hit;
    logic [3:0]       in_lane_mask;
    logic [7:0]       ld_byte;
    logic [WIDTH-1:0] ld_data;

    always_comb begin
        in_is_word  = (w_op_code_6 == OP_LW) || (w_op_code_6 == OP_SW);
        in_is_store = (w_op_code_6 == OP_SW) || (w_op_code_6 == OP_SB);
        in_is_mem   = in_is_word || in_is_store ||
                      (w_op_code_6 == OP_LB) || (w_op_code_6 == OP_LBU);
        // Big-endian: lane 0 is the most significant byte.
        case (w_alu_result_x[1:0])
            2'd0: in_lane_mask = 4'b1000;
            2'd1: in_lane_mask = 4'b0100;
            2'd2: in_lane_mask = 4'b0010;
            2'd3: in_lane_mask = 4'b0001;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_hit = in_is_word && (w_alu_result_x[1:0] != 2'b00);
`else
    assign trap_hit = 1'b0;
`endif

    always_comb begin
        case (lane_q)
            2'd0: ld_byte = w_mem_rdata_x[31:24];
            2'd1: ld_byte = w_mem_rdata_x[23:16];
            2'd2: ld_byte = w_mem_rdata_x[15:8];
            2'd3: ld_byte = w_mem_rdata_x[7:0];
        endcase
        if (op_q == OP_LW)
            ld_data = w_mem_rdata_x;
        else if (op_q == OP_LB)
            ld_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
        else
            ld_data = {{(WIDTH-8){1'b0}}, ld_byte};
    end

    always_comb begin
        // NOTE: every _d starts from its _q (or its idle value) so no path leaves a signal unassigned and infers a latch.
        state_d    = state_q;
        op_d       = op_q;
        lane_d     = lane_q;
        dest_d     = dest_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_reg_d   = wb_reg_q;
        misalign_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_valid_1) begin
                    op_d   = w_op_code_6;
                    lane_d = w_alu_result_x[1:0];
                    dest_d = w_dest_reg_5;
                    if (trap_hit) begin
                        state_d    = S_TRAP;
                        misalign_d = 1'b1;
                    end else if (in_is_mem) begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        we_d    = in_is_store;
                        addr_d  = {w_alu_result_x[WIDTH-1:2], 2'b00};
                        be_d    = in_is_word ? 4'b1111 : in_lane_mask;
                        wdata_d = (w_op_code_6 == OP_SW) ? w_store_data_x
                                                         : {4{w_store_data_x[7:0]}};
                    end else begin
                        state_d    = S_WB;
                        wb_valid_d = 1'b1;
                        wb_data_d  = w_alu_result_x;
                        wb_reg_d   = w_dest_reg_5;
                    end
                end
            end
            S_REQ: begin
                if (w_mem_ack_1) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_WB;
                        wb_valid_d = 1'b1;
                        wb_data_d  = ld_data;
                        wb_reg_d   = dest_q;
                    end
                end
            end
            S_WB:    state_d = S_IDLE;
            S_TRAP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            lane_q     <= '0;
            dest_q     <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_reg_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            lane_q     <= lane_d;
            dest_q     <= dest_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_reg_q   <= wb_reg_d;
            misalign_q <= misalign_d;
        end
    end

    assign w_ready_1     = (state_q == S_IDLE);
    assign w_mem_req_1   = req_q;
    assign w_mem_we_1    = we_q;
    assign w_mem_addr_x  = addr_q;
    assign w_mem_wdata_x = wdata_q;
    assign w_mem_be_4    = be_q;
    assign w_wb_valid_1  = wb_valid_q;
    assign w_wb_data_x   = wb_data_q;
    assign w_wb_reg_5    = wb_reg_q;
    assign w_misalign_1  = misalign_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand sequences and a randomized run
// against a behavioural reference model. Honours LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_load_store_unit;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SW  = 6'h2B;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum {K_ALU, K_LOAD, K_STORE, K_TRAP} kind_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  dest;
        logic [31:0] rdata;
        int          waits;
        kind_t       kind;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
    } vec_t;

    typedef struct {
        kind_t       kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] wb;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  w_op_code_6 = '0;
    logic        w_valid_1 = 1'b0;
    logic        w_ready_1;
    logic [31:0] w_alu_result_x = '0;
    logic [31:0] w_store_data_x = '0;
    logic [4:0]  w_dest_reg_5 = '0;
    logic        w_mem_req_1, w_mem_we_1;
    logic [31:0] w_mem_addr_x, w_mem_wdata_x;
    logic [3:0]  w_mem_be_4;
    logic        w_mem_ack_1 = 1'b0;
    logic [31:0] w_mem_rdata_x = '0;
    logic        w_wb_valid_1;
    logic [31:0] w_wb_data_x;
    logic [4:0]  w_wb_reg_5;
    logic        w_misalign_1;

    int n_vec = 0;
    int n_bad = 0;

    load_store_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .w_op_code_6(w_op_code_6), .w_valid_1(w_valid_1), .w_ready_1(w_ready_1),
        .w_alu_result_x(w_alu_result_x), .w_store_data_x(w_store_data_x), .w_dest_reg_5(w_dest_reg_5),
        .w_mem_req_1(w_mem_req_1), .w_mem_we_1(w_mem_we_1), .w_mem_addr_x(w_mem_addr_x),
        .w_mem_wdata_x(w_mem_wdata_x), .w_mem_be_4(w_mem_be_4),
        .w_mem_ack_1(w_mem_ack_1), .w_mem_rdata_x(w_mem_rdata_x),
        .w_wb_valid_1(w_wb_valid_1), .w_wb_data_x(w_wb_data_x), .w_wb_reg_5(w_wb_reg_5),
        .w_misalign_1(w_misalign_1)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_mem_op(input logic [5:0] op);
        return op == OP_LW || op == OP_SW || op == OP_LB || op == OP_LBU || op == OP_SB;
    endfunction

    // Reference model: expected access and result from the ISA rules, using plain arithmetic.
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] addr,
                                   input logic [31:0] sdata, input logic [31:0] rdata);
        exp_t        e;
        int unsigned lane = addr % 4;
        logic [31:0] byte_val = (rdata >> (8 * (3 - lane))) & 32'hFF;
        logic [31:0] lane_mask = 32'd1 << (3 - lane);
        e.addr  = addr - lane;
        e.wdata = 32'h0;
        e.wb    = 32'h0;
        e.be    = 4'b1111;
        e.kind  = K_ALU;
        if ((op == OP_LW || op == OP_SW) && lane != 0 && TRAP_EN)
            e.kind = K_TRAP;
        else if (op == OP_LW) begin
            e.kind = K_LOAD;
            e.wb   = rdata;
        end else if (op == OP_LB || op == OP_LBU) begin
            e.kind = K_LOAD;
            e.be   = 4'(lane_mask);
            e.wb   = (op == OP_LB && byte_val >= 128) ? byte_val + 32'hFFFF_FF00 : byte_val;
        end else if (op == OP_SW) begin
            e.kind  = K_STORE;
            e.wdata = sdata;
        end else if (op == OP_SB) begin
            e.kind  = K_STORE;
            e.be    = 4'(lane_mask);
            e.wdata = (sdata & 32'hFF) * 32'h0101_0101;
        end else
            e.wb = addr;
        return e;
    endfunction

    // Drives one instruction from a negedge and follows it to completion, checking every visible cycle.
    task automatic run_txn(input string name, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [4:0] dest, input logic [31:0] rdata,
                           input int waits, input kind_t kind, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
        check({name, " ready_before"}, 32'(w_ready_1), 32'd1);
        w_op_code_6    = op;
        w_alu_result_x = addr;
        w_store_data_x = sdata;
        w_dest_reg_5   = dest;
        w_valid_1      = 1'b1;
        @(negedge clock);
        w_valid_1 = 1'b0;
        case (kind)
            K_ALU: begin
                check({name, " wb_valid"}, 32'(w_wb_valid_1), 32'd1);
                check({name, " wb_data"}, w_wb_data_x, exp_wb);
                check({name, " wb_reg"}, 32'(w_wb_reg_5), 32'(dest));
                check({name, " req_idle"}, 32'(w_mem_req_1), 32'd0);
                check({name, " ready_wb"}, 32'(w_ready_1), 32'd0);
                @(negedge clock);
                check({name, " wb_done"}, 32'(w_wb_valid_1), 32'd0);
                check({name, " ready_after"}, 32'(w_ready_1), 32'd1);
            end
            K_TRAP: begin
                check({name, " misalign"}, 32'(w_misalign_1), 32'd1);
                check({name, " trap_req"}, 32'(w_mem_req_1), 32'd0);
                check({name, " trap_wb"}, 32'(w_wb_valid_1), 32'd0);
                check({name, " trap_ready"}, 32'(w_ready_1), 32'd0);
                @(negedge clock);
                check({name, " misalign_done"}, 32'(w_misalign_1), 32'd0);
                check({name, " trap_req2"}, 32'(w_mem_req_1), 32'd0);
                check({name, " trap_wb2"}, 32'(w_wb_valid_1), 32'd0);
                check({name, " ready_after"}, 32'(w_ready_1), 32'd1);
            end
            default: begin
                check({name, " misalign0"}, 32'(w_misalign_1), 32'd0);
                for (int k = 0; k <= waits; k++) begin
                    check({name, " req"}, 32'(w_mem_req_1), 32'd1);
                    check({name, " we"}, 32'(w_mem_we_1), (kind == K_STORE) ? 32'd1 : 32'd0);
                    check({name, " addr"}, w_mem_addr_x, exp_addr);
                    check({name, " be"}, 32'(w_mem_be_4), 32'(exp_be));
                    if (kind == K_STORE)
                        check({name, " wdata"}, w_mem_wdata_x, exp_wdata);
                    check({name, " wb_quiet"}, 32'(w_wb_valid_1), 32'd0);
                    w_mem_ack_1   = (k == waits);
                    w_mem_rdata_x = (k == waits) ? rdata : $urandom;
                    @(negedge clock);
                end
                w_mem_ack_1 = 1'b0;
                check({name, " req_drop"}, 32'(w_mem_req_1), 32'd0);
                if (kind == K_LOAD) begin
                    check({name, " wb_valid"}, 32'(w_wb_valid_1), 32'd1);
                    check({name, " wb_data"}, w_wb_data_x, exp_wb);
                    check({name, " wb_reg"}, 32'(w_wb_reg_5), 32'(dest));
                    check({name, " ready_wb"}, 32'(w_ready_1), 32'd0);
                    @(negedge clock);
                    check({name, " wb_done"}, 32'(w_wb_valid_1), 32'd0);
                    check({name, " ready_after"}, 32'(w_ready_1), 32'd1);
                end else begin
                    check({name, " store_no_wb"}, 32'(w_wb_valid_1), 32'd0);
                    check({name, " ready_after"}, 32'(w_ready_1), 32'd1);
                end
            end
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[10];
        exp_t e;
        logic [5:0]  op;
        logic [31:0] addr;

        vecs[0] = '{OP_LW,  32'h100, 32'h0,        5'd8,  32'hDEAD_BEEF, 0, K_LOAD,  32'h100, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        vecs[1] = '{OP_LB,  32'h203, 32'h0,        5'd5,  32'h1234_56F0, 1, K_LOAD,  32'h200, 4'b0001, 32'h0,        32'hFFFF_FFF0};
        vecs[2] = '{OP_LBU, 32'h203, 32'h0,        5'd6,  32'h1234_56F0, 0, K_LOAD,  32'h200, 4'b0001, 32'h0,        32'h0000_00F0};
        vecs[3] = '{OP_SB,  32'h301, 32'h0000_00AB, 5'd1, 32'h0,         3, K_STORE, 32'h300, 4'b0100, 32'hABAB_ABAB, 32'h0};
        vecs[4] = '{6'h00,  32'h7,   32'h0,        5'd3,  32'h0,         0, K_ALU,   32'h0,   4'b0000, 32'h0,        32'h7};
        vecs[5] = '{OP_SW,  32'h404, 32'hCAFE_F00D, 5'd2, 32'h0,         2, K_STORE, 32'h404, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[6] = '{OP_LB,  32'h500, 32'h0,        5'd7,  32'h7F00_0000, 0, K_LOAD,  32'h500, 4'b1000, 32'h0,        32'h0000_007F};
        vecs[7] = '{OP_LB,  32'h601, 32'h0,        5'd9,  32'h0080_1234, 1, K_LOAD,  32'h600, 4'b0100, 32'h0,        32'hFFFF_FF80};
        vecs[8] = '{OP_SB,  32'h703, 32'h1234_5666, 5'd4, 32'h0,         0, K_STORE, 32'h700, 4'b0001, 32'h6666_6666, 32'h0};
        vecs[9] = '{6'h08,  32'hFFFF_FFFF, 32'h0,  5'd0,  32'h0,         0, K_ALU,   32'h0,   4'b0000, 32'h0,        32'hFFFF_FFFF};

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst req", 32'(w_mem_req_1), 32'd0);
        check("rst we", 32'(w_mem_we_1), 32'd0);
        check("rst addr", w_mem_addr_x, 32'd0);
        check("rst wdata", w_mem_wdata_x, 32'd0);
        check("rst be", 32'(w_mem_be_4), 32'd0);
        check("rst wb_valid", 32'(w_wb_valid_1), 32'd0);
        check("rst wb_data", w_wb_data_x, 32'd0);
        check("rst wb_reg", 32'(w_wb_reg_5), 32'd0);
        check("rst misalign", 32'(w_misalign_1), 32'd0);
        check("rst ready", 32'(w_ready_1), 32'd1);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 10; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].dest,
                    vecs[i].rdata, vecs[i].waits, vecs[i].kind, vecs[i].exp_addr, vecs[i].exp_be,
                    vecs[i].exp_wdata, vecs[i].exp_wb);

        // Misaligned SW: trapped when the option is built in, otherwise issued to the aligned word.
        if (TRAP_EN)
            run_txn("sw_misalign", OP_SW, 32'h402, 32'h1122_3344, 5'd1, 32'h0, 0, K_TRAP,
                    32'h0, 4'b0000, 32'h0, 32'h0);
        else
            run_txn("sw_misalign", OP_SW, 32'h402, 32'h1122_3344, 5'd1, 32'h0, 0, K_STORE,
                    32'h400, 4'b1111, 32'h1122_3344, 32'h0);

        // Valid held through WB is only taken once ready returns.
        w_op_code_6 = 6'h00; w_alu_result_x = 32'h7; w_dest_reg_5 = 5'd3; w_valid_1 = 1'b1;
        @(negedge clock);
        w_alu_result_x = 32'h55; w_dest_reg_5 = 5'd9;
        check("hold wb1_data", w_wb_data_x, 32'h7);
        check("hold ready_low", 32'(w_ready_1), 32'd0);
        @(negedge clock);
        check("hold wb_gap", 32'(w_wb_valid_1), 32'd0);
        check("hold ready_back", 32'(w_ready_1), 32'd1);
        @(negedge clock);
        w_valid_1 = 1'b0;
        check("hold wb2_valid", 32'(w_wb_valid_1), 32'd1);
        check("hold wb2_data", w_wb_data_x, 32'h55);
        check("hold wb2_reg", 32'(w_wb_reg_5), 32'd9);
        @(negedge clock);

        // Ack while idle has no effect.
        w_mem_ack_1 = 1'b1; w_mem_rdata_x = 32'hFFFF_FFFF;
        @(negedge clock);
        w_mem_ack_1 = 1'b0;
        check("idle_ack req", 32'(w_mem_req_1), 32'd0);
        check("idle_ack wb", 32'(w_wb_valid_1), 32'd0);
        check("idle_ack ready", 32'(w_ready_1), 32'd1);

        // Reset during REQ, with the ack arriving a cycle late.
        w_op_code_6 = OP_LW; w_alu_result_x = 32'h800; w_dest_reg_5 = 5'd12; w_valid_1 = 1'b1;
        @(negedge clock);
        w_valid_1 = 1'b0;
        check("rstreq req_up", 32'(w_mem_req_1), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        w_mem_ack_1 = 1'b1; w_mem_rdata_x = 32'h1357_9BDF;
        check("rstreq req_low", 32'(w_mem_req_1), 32'd0);
        check("rstreq ready", 32'(w_ready_1), 32'd1);
        @(negedge clock);
        w_mem_ack_1 = 1'b0;
        check("rstreq no_wb", 32'(w_wb_valid_1), 32'd0);
        check("rstreq req_still_low", 32'(w_mem_req_1), 32'd0);
        check("rstreq ready2", 32'(w_ready_1), 32'd1);
        @(negedge clock);
        check("rstreq no_wb2", 32'(w_wb_valid_1), 32'd0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] sdata, rdata;
            logic [4:0]  dest;
            int          waits;
            case ($urandom_range(0, 5))
                0: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_LB;
                3: op = OP_LBU;
                4: op = OP_SB;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    if (is_mem_op(op)) op = 6'h00;
                end
            endcase
            addr  = $urandom;
            sdata = $urandom;
            rdata = $urandom;
            dest  = 5'($urandom_range(0, 31));
            waits = $urandom_range(0, 3);
            e = model(op, addr, sdata, rdata);
            run_txn($sformatf("rnd%0d", i), op, addr, sdata, dest, rdata, waits, e.kind,
                    e.addr, e.be, e.wdata, e.wb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage of the pd3 MIPS datapath, directly downstream of the ALU. It accepts one executed instruction at a time: opcode, ALU result (effective address or arithmetic result), store data and destination register. It performs LW/SW/LB/LBU/SB accesses over a request/acknowledge data-memory port, with big-endian byte-lane steering and sign/zero extension. It hands a single-cycle write-back record to the register file; non-memory ops pass straight through to write-back.

## Interface
Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- w_op_code_6  in  6  opcode in the shared ISA encoding (`LW`, `SW`, `LB`, `LBU`, `SB`, all others non-memory).
- w_valid_1  in  1  upstream holds a valid instruction.
- w_ready_1  out  1  unit can accept; high only in IDLE.
- w_alu_result_x  in  WIDTH  ALU output: effective address for memory ops, result otherwise.
- w_store_data_x  in  WIDTH  rt value for SW/SB.
- w_dest_reg_5  in  5  write-back register index.
- w_mem_req_1  out  1  memory request.
- w_mem_we_1  out  1  1 = write, 0 = read.
- w_mem_addr_x  out  WIDTH  word address; bits [1:0] always 0.
- w_mem_wdata_x  out  WIDTH  write data.
- w_mem_be_4  out  4  byte enables; bit 3 = bits 31:24.
- w_mem_ack_1  in  1  memory completes the request in this cycle.
- w_mem_rdata_x  in  WIDTH  read data; valid when ack is high.
- w_wb_valid_1  out  1  one-cycle write-back strobe.
- w_wb_data_x  out  WIDTH  write-back value.
- w_wb_reg_5  out  5  write-back register index.
- w_misalign_1  out  1  one-cycle misaligned-word-access flag.

## Operation
- Accept: occurs when w_valid_1 && w_ready_1. Opcode, address, store data and dest are latched.
- States:
  - IDLE: accept a memory op → REQ; accept a non-memory op → WB, with wb data = w_alu_result_x.
  - REQ: hold req/we/addr/wdata/be stable until ack. On ack, a load → WB with extracted data; a store → IDLE.
  - WB: assert w_wb_valid_1 for exactly one cycle → IDLE.
- Address: w_mem_addr_x = {addr[31:2], 2'b00}. Lane = addr[1:0], big-endian: lane 0 → be 4'b1000 and bits 31:24; lane 3 → be 4'b0001 and bits 7:0.
- Loads and stores:
  - LW: be 4'b1111; wb data = rdata.
  - LB: selected byte sign-extended. LBU: selected byte zero-extended. be is the lane mask.
  - SW: be 4'b1111; wdata = store data.
  - SB: wdata = store data[7:0] replicated into all four bytes; be is the lane mask.
- Write-back:
  - Stores never produce write-back.
  - Write-back to reg 0 is still strobed; the register file discards it.
- Ack sampled in any state other than REQ is ignored.
- w_valid_1 while not ready is not accepted; upstream holds its values.

## Timing
- All outputs are registered.
- Reset values: w_mem_req_1 0, w_mem_we_1 0, w_mem_addr_x 0, w_mem_wdata_x 0, w_mem_be_4 0, w_wb_valid_1 0, w_wb_data_x 0, w_wb_reg_5 0, w_misalign_1 0, state IDLE, so w_ready_1 = 1.
- Non-memory op accepted in cycle N: wb_valid in N+1; ready again in N+2.
- Memory op accepted in cycle N: req high from N+1.
- Ack in cycle M ≥ N+1:
  - req drops in M+1.
  - Load: wb_valid in M+1; ready in M+2.
  - Store: ready in M+1.
- Zero-wait memory gives load latency 2 cycles and store occupancy 2 cycles.
- Reset asserted mid-REQ: at the next edge req drops and state is IDLE. A late ack is ignored and no write-back is produced.

## Configuration
- LSU_MISALIGN_TRAP_EN:
  - Defined: LW/SW with addr[1:0] ≠ 0 are not issued. The unit goes IDLE → WB-less completion: w_misalign_1 pulses in N+1, with no req and no wb, and ready returns in N+2.
  - Undefined: w_misalign_1 is tied 0 and misaligned LW/SW proceed using the aligned word address.

## Test plan
- LW, addr 0x100, ack in the same cycle as req, rdata 0xDEADBEEF, dest 8 → wb_valid two cycles after accept, data 0xDEADBEEF, reg 8, mem_addr 0x100, be 4'b1111.
- LB, addr 0x203, rdata 0x123456F0 → wb data 0xFFFFFFF0. LBU at the same address → 0x000000F0.
- SB, addr 0x301, store data 0x000000AB, ack after 3 wait cycles → req held 4 cycles, addr 0x300, wdata 0xABABABAB, be 4'b0100, no wb_valid.
- Non-memory op, result 0x7, dest 3 → wb_valid one cycle after accept with data 0x7, reg 3. A valid held during WB is accepted only after ready returns.
- Reset pulsed during REQ with ack arriving one cycle later → req low after the reset edge, ack ignored, no wb_valid, ready = 1.
- With LSU_MISALIGN_TRAP_EN: SW to addr 0x402 → w_misalign_1 pulses once, req never asserted. Without the macro: same stimulus writes addr 0x400 with be 4'b1111.
